rvfi_mem_arbiter: RTL
=====================

Name: rvfi_mem_arbiter

Overview:
- Two-master round-robin arbiter sharing one native-style memory port (valid/ready, addr/wdata/wstrb/rdata, instr) between two requesters. Typical pairing: a core's memory port plus a second agent (debug loader, DMA, or a second core) in a formal or sim harness.
- Sequences one transfer at a time and holds the grant until the slave handshake completes.
- Monitors slave wait time against a bound and flags master protocol violations, for use as formal liveness and assumption hooks.

Parameters:
- XLEN, 32, data/address width.
- MAX_WAIT, 16, slave wait cycles within one grant before timeout asserts (1..255).
- WAIT_BITS, 8, width of the wait counter; must satisfy MAX_WAIT <= 2^WAIT_BITS-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_mem_valid  input  1  master 0 request.
- m0_mem_instr  input  1  master 0 instruction-fetch qualifier.
- m0_mem_addr  input  XLEN  master 0 address.
- m0_mem_wdata  input  XLEN  master 0 write data.
- m0_mem_wstrb  input  4  master 0 byte strobes; 0 means read.
- m0_mem_ready  output  1  master 0 completion pulse.
- m0_mem_rdata  output  XLEN  master 0 read data.
- m1_mem_*  same set as m0, for master 1.
- s_mem_valid  output  1  slave request.
- s_mem_instr  output  1  slave instruction-fetch qualifier.
- s_mem_addr  output  XLEN  slave address.
- s_mem_wdata  output  XLEN  slave write data.
- s_mem_wstrb  output  4  slave byte strobes.
- s_mem_ready  input  1  slave completion.
- s_mem_rdata  input  XLEN  slave read data.
- grant  output  2  one-hot current owner; 0 when idle.
- timeout  output  1  sticky: wait bound hit.
- proto_err  output  1  sticky: master dropped valid before ready.

Behaviour:
- Reset values: state IDLE, grant=0, last_grant=1 (so m0 wins the first tie), wait_cnt=0, timeout=0, proto_err=0. All s_mem_* outputs 0 and all mN_mem_ready 0 while in reset and while IDLE. Reset mid-transfer abandons the transfer, with no ready pulse to either master.
- States: IDLE, GNT0, GNT1. State and grant are registered. s_mem_valid is combinational: m{g}_mem_valid gated by the GNTg state.
- Arbitration from IDLE:
  - only m0 valid -> GNT0.
  - only m1 valid -> GNT1.
  - both valid -> the master other than last_grant.
  - neither -> stay IDLE.
- Latency: request first seen in cycle N; s_mem_valid asserts in cycle N+1.
- In GNTg:
  - s_mem_instr/addr/wdata/wstrb mux from master g.
  - mg_mem_ready = s_mem_ready, combinational, same cycle.
  - s_mem_rdata is broadcast to both mN_mem_rdata. The non-granted master's ready is always 0.
- Completion (GNTg and s_mem_ready):
  - last_grant <= g.
  - If the other master is valid, go directly to its GNT state (back-to-back, no idle bubble). Otherwise go to IDLE.
  - The completing master's valid is ignored in this arbitration decision.
- Wait counter:
  - Cleared on entry to any GNT state.
  - Increments each GNT cycle with s_mem_ready=0, saturating at MAX_WAIT.
  - timeout <= 1 when wait_cnt == MAX_WAIT and ready is still low. Sticky until reset; does not alter arbitration.
- Protocol error: in GNTg with mg_mem_valid=0 (valid dropped before ready) -> proto_err <= 1 (sticky) and state -> IDLE the next cycle. s_mem_valid is already low that cycle, through the combinational gating.
- Simultaneous s_mem_ready and a new request from the other master: the completion rule applies, so the next state is the other master's GNT.
- s_mem_ready while IDLE is ignored; no master ready pulse.
- grant is 2'b01 in GNT0, 2'b10 in GNT1, 0 otherwise.

Decomposition:
- Shared package rvfi_mem_pkg holds:
  - state encoding constants (ST_IDLE=0, ST_GNT0=1, ST_GNT1=2);
  - the localparam for the strobe width (4).
- One sub-module is natural: rvfi_mem_wait_mon. It holds the saturating counter plus the sticky timeout, with inputs clk, reset, start, busy and ready. It is reusable for the direct core-to-memory harness.
- The mux and FSM stay in the top module.

Test Plan:
- Reset, then m0 read at 0x100 with the slave ready after 2 wait cycles -> s_mem_valid rises 1 cycle after the request; m0_mem_ready pulses in the 3rd GNT0 cycle; rdata 0xDEADBEEF is delivered; grant returns to 0.
- m0 and m1 both valid from IDLE, slave always ready -> grants go GNT0, GNT1, GNT0, ... with no IDLE cycle between; 4 transfers complete in 5 cycles.
- m1 write 0x200, wdata 0x12345678, wstrb 4'b0011, with m0 idle -> the s_mem_* fields match m1 exactly; m0_mem_ready stays 0 throughout.
- MAX_WAIT=4, slave never ready -> timeout asserts after 4 wait cycles and stays high; grant held at GNT0 indefinitely.
- m0 drops valid in the 2nd GNT0 cycle -> proto_err=1 the next cycle; state IDLE; s_mem_valid=0.
- reset asserted mid-GNT1 with s_mem_ready=0 -> next cycle all outputs are 0; the next tie is granted to m0.

Source files
------------

// File: rtl/rvfi_mem_pkg.sv
// Shared types for the two-master memory arbiter: FSM state encoding and
// the byte-strobe width of the native memory port.
package rvfi_mem_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rvfi_mem_wait_mon.sv
// Saturating slave wait counter with a sticky timeout flag; usable wherever a
// single granted transfer waits on a slave ready.
module rvfi_mem_wait_mon #(
  parameter int MAX_WAIT  = 16,
  parameter int WAIT_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  localparam logic [WAIT_BITS-1:0] MAX_CNT = WAIT_BITS'(MAX_WAIT);

  logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;

  // start clears the count so the first cycle of a new grant begins at zero
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (start) begin
      wait_cnt_d = '0;
    end else if (busy && !ready) begin
      if (wait_cnt_q == MAX_CNT) begin
        timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/rvfi_mem_arbiter.sv
// Round-robin arbiter sharing one native memory port between two masters,
// with a slave wait-bound monitor and a sticky master protocol-error flag.
module rvfi_mem_arbiter
  import rvfi_mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_WAIT  = 16,
  parameter int WAIT_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_mem_valid,
  input  logic              m0_mem_instr,
  input  logic [XLEN-1:0]   m0_mem_addr,
  input  logic [XLEN-1:0]   m0_mem_wdata,
  input  logic [STRB_W-1:0] m0_mem_wstrb,
  output logic              m0_mem_ready,
  output logic [XLEN-1:0]   m0_mem_rdata,
  input  logic              m1_mem_valid,
  input  logic              m1_mem_instr,
  input  logic [XLEN-1:0]   m1_mem_addr,
  input  logic [XLEN-1:0]   m1_mem_wdata,
  input  logic [STRB_W-1:0] m1_mem_wstrb,
  output logic              m1_mem_ready,
  output logic [XLEN-1:0]   m1_mem_rdata,
  output logic              s_mem_valid,
  output logic              s_mem_instr,
  output logic [XLEN-1:0]   s_mem_addr,
  output logic [XLEN-1:0]   s_mem_wdata,
  output logic [STRB_W-1:0] s_mem_wstrb,
  input  logic              s_mem_ready,
  input  logic [XLEN-1:0]   s_mem_rdata,
  output logic [1:0]        grant,
  output logic              timeout,
  output logic              proto_err
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       proto_err_q, proto_err_d;
  logic       gnt0, gnt1;
  logic       wait_start, wait_busy;

  // Gating with reset keeps the slave port and ready pulses quiet during the
  // reset cycle even though the state register has not cleared yet.
  always_comb begin
    gnt0         = !reset && (state_q == ST_GNT0);
    gnt1         = !reset && (state_q == ST_GNT1);
    s_mem_valid  = (gnt0 && m0_mem_valid) || (gnt1 && m1_mem_valid);
    s_mem_instr  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    if (gnt0) begin
      s_mem_instr = m0_mem_instr;
      s_mem_addr  = m0_mem_addr;
      s_mem_wdata = m0_mem_wdata;
      s_mem_wstrb = m0_mem_wstrb;
    end else if (gnt1) begin
      s_mem_instr = m1_mem_instr;
      s_mem_addr  = m1_mem_addr;
      s_mem_wdata = m1_mem_wdata;
      s_mem_wstrb = m1_mem_wstrb;
    end
    m0_mem_ready = gnt0 && s_mem_ready;
    m1_mem_ready = gnt1 && s_mem_ready;
    m0_mem_rdata = s_mem_rdata;
    m1_mem_rdata = s_mem_rdata;
  end

  // On completion only the other master is considered, giving back-to-back
  // alternation without an idle bubble.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    proto_err_d  = proto_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_mem_valid && (!m1_mem_valid || last_grant_q)) begin
          state_d = ST_GNT0;
        end else if (m1_mem_valid) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_mem_valid) begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (s_mem_ready) begin
          last_grant_d = 1'b0;
          state_d      = m1_mem_valid ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_mem_valid) begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (s_mem_ready) begin
          last_grant_d = 1'b1;
          state_d      = m0_mem_valid ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    grant_d = (state_d == ST_GNT0) ? 2'b01 :
              (state_d == ST_GNT1) ? 2'b10 : 2'b00;
    wait_start = (state_d != ST_IDLE) && (state_d != state_q);
    wait_busy  = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      proto_err_q  <= proto_err_d;
    end
  end

  rvfi_mem_wait_mon #(
    .MAX_WAIT  (MAX_WAIT),
    .WAIT_BITS (WAIT_BITS)
  ) u_wait_mon (
    .clk     (clk),
    .reset   (reset),
    .start   (wait_start),
    .busy    (wait_busy),
    .ready   (s_mem_ready),
    .timeout (timeout)
  );

  assign grant     = grant_q;
  assign proto_err = proto_err_q;

endmodule
